// File: rtl/array_11_port_ctrl.sv
// Zero-fills and then arbitrates the single RW port of the 32 x 228 array between one writer and one reader.
// Latency: write commits at the accept edge; read data reaches the response FIFO one edge after the read accept.
// Backpressure: reads are issued only while the 2-entry response FIFO (plus any read in flight) has room.

// Small generic FIFO: registered storage, head visible combinationally, simultaneous push/pop allowed.
// Latency: an entry pushed at edge N is visible at the head after edge N.
// Backpressure: the caller must not push when full; pops happen on out_vld & out_rdy.
module fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         core_clk,
  input  logic                         arst_n,
  input  logic                         in_vld,
  input  logic [W-1:0]                 in_dat,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic [W-1:0]                 out_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  store_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          pop;

  assign pop     = out_vld & out_rdy;
  assign out_vld = (count_q != '0);
  assign out_dat = store_q[rd_ptr_q];
  assign count   = count_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage, pointers and occupancy; storage is cleared so the head reads zero out of reset.
  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) store_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (in_vld) begin
        store_q[wr_ptr_q] <= in_dat;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(in_vld) - CW'(pop);
    end
  end
endmodule

module array_11_port_ctrl #(
  parameter int unsigned INIT_EN = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  output logic         init_done,
  input  logic         w_valid,
  output logic         w_ready,
  input  logic [4:0]   w_addr,
  input  logic [1:0]   w_mask,
  input  logic [227:0] w_data,
  input  logic         r_valid,
  output logic         r_ready,
  input  logic [4:0]   r_addr,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [227:0] resp_data,
  output logic         mem_en,
  output logic         mem_wmode,
  output logic [4:0]   mem_addr,
  output logic [1:0]   mem_wmask,
  output logic [227:0] mem_wdata,
  input  logic [227:0] mem_rdata
);
  localparam logic [4:0] LAST_ADDR = 5'd31;

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  // Everything the macro port sees besides the enable; held across idle cycles.
  typedef struct packed {
    logic         wmode;
    logic [4:0]   addr;
    logic [1:0]   wmask;
    logic [227:0] wdata;
  } mem_cmd_t;

  localparam state_t RESET_STATE = (INIT_EN != 0) ? S_INIT : S_RUN;

  state_t   state_q, state_d;
  logic [4:0] cnt_q;
  logic     init_done_q;
  logic     rr_rd_q;       // 1: read wins the next contested cycle
  logic     inflight_q;    // a read was issued last cycle; its data is on mem_rdata now
  mem_cmd_t hold_q, cmd;

  logic       sweep, grant_wr, grant_rd, rd_elig, credit_ok, contested, resp_pop;
  logic [1:0] fifo_count;
  logic [2:0] occ;

  assign resp_pop  = resp_valid & resp_ready;
  // Slots committed to responses: stored entries plus the read in flight, minus the one leaving now.
  assign occ       = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, resp_pop};
  assign credit_ok = (occ < 3'd2);
  assign rd_elig   = r_valid & credit_ok;
  assign init_done = init_done_q;

  // Next state and single-slot arbitration; reset_n gating keeps the port quiet while reset is held.
  always_comb begin
    state_d   = state_q;
    sweep     = 1'b0;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    contested = 1'b0;
    case (state_q)
      S_INIT: begin
        sweep = reset_n;
        if (cnt_q == LAST_ADDR) state_d = S_RUN;
      end
      S_RUN: begin
        if (reset_n) begin
          if (w_valid && rd_elig) begin
            contested = 1'b1;
            grant_rd  = rr_rd_q;
            grant_wr  = ~rr_rd_q;
          end else begin
            grant_wr = w_valid;
            grant_rd = rd_elig;
          end
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  // Macro command mux: sweep, granted write, granted read, or the held command when idle.
  always_comb begin
    cmd    = hold_q;
    mem_en = sweep | grant_wr | grant_rd;
    if (sweep) begin
      cmd.wmode = 1'b1;
      cmd.addr  = cnt_q;
      cmd.wmask = 2'b11;
      cmd.wdata = '0;
    end else if (grant_wr) begin
      cmd.wmode = 1'b1;
      cmd.addr  = w_addr;
      cmd.wmask = w_mask;
      cmd.wdata = w_data;
    end else if (grant_rd) begin
      cmd.wmode = 1'b0;
      cmd.addr  = r_addr;
    end
  end

  assign mem_wmode = cmd.wmode;
  assign mem_addr  = cmd.addr;
  assign mem_wmask = cmd.wmask;
  assign mem_wdata = cmd.wdata;
  assign w_ready   = grant_wr;
  assign r_ready   = grant_rd;

  // Sequencer state: sweep counter, init flag and state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RESET_STATE;
      cnt_q       <= '0;
      init_done_q <= (INIT_EN == 0);
    end else begin
      state_q <= state_d;
      if (state_q == S_INIT) begin
        cnt_q <= cnt_q + 5'd1;
        if (cnt_q == LAST_ADDR) init_done_q <= 1'b1;
      end
    end
  end

  // Round-robin pointer, in-flight read marker and the held port command.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_rd_q    <= 1'b1;
      inflight_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      if (contested) rr_rd_q <= grant_wr;
      inflight_q <= grant_rd;
      if (mem_en) hold_q <= cmd;
    end
  end

  fifo #(.W(228), .DEPTH(2)) u_resp_fifo (
    .core_clk (clock),
    .arst_n   (reset_n),
    .in_vld   (inflight_q),
    .in_dat   (mem_rdata),
    .out_vld  (resp_valid),
    .out_rdy  (resp_ready),
    .out_dat  (resp_data),
    .count    (fifo_count)
  );
endmodule

// File: tb/tb_array_11_port_ctrl.sv
module tb_array_11_port_ctrl;
  logic         clock = 1'b0;
  logic         reset_n;
  logic         init_done;
  logic         w_valid, w_ready;
  logic [4:0]   w_addr;
  logic [1:0]   w_mask;
  logic [227:0] w_data;
  logic         r_valid, r_ready;
  logic [4:0]   r_addr;
  logic         resp_valid, resp_ready;
  logic [227:0] resp_data;
  logic         mem_en, mem_wmode;
  logic [4:0]   mem_addr;
  logic [1:0]   mem_wmask;
  logic [227:0] mem_wdata;
  logic [227:0] mem_rdata = '0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  array_11_port_ctrl #(.INIT_EN(1)) dut (
    .clock(clock), .reset_n(reset_n), .init_done(init_done),
    .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_mask(w_mask), .w_data(w_data),
    .r_valid(r_valid), .r_ready(r_ready), .r_addr(r_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .mem_en(mem_en), .mem_wmode(mem_wmode), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Behavioural macro: masked lane writes, read data registered one cycle after the enable.
  // Contents start as all-ones so the zero-fill is observable.
  logic [227:0] arr [32];
  logic model_ready = 1'b0;
  always @(posedge clock) begin
    if (!model_ready) begin
      for (int i = 0; i < 32; i++) arr[i] <= '1;
      model_ready <= 1'b1;
    end else if (mem_en) begin
      if (mem_wmode) begin
        if (mem_wmask[0]) arr[mem_addr][113:0]   <= mem_wdata[113:0];
        if (mem_wmask[1]) arr[mem_addr][227:114] <= mem_wdata[227:114];
      end else begin
        mem_rdata <= arr[mem_addr];
      end
    end
  end

  // Drive point is 1 time unit after the falling edge; checks follow at +2.
  task automatic next_cycle();
    @(negedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; w_valid = 0; r_valid = 0; resp_ready = 0;
    w_addr = '0; w_mask = '0; w_data = '0; r_addr = '0;
    next_cycle(); next_cycle(); #1;
    n_cmp++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL rst_init_done: got %b want 0", init_done); end
    n_cmp++; if (w_ready !== 1'b0) begin n_fail++; $display("FAIL rst_w_ready: got %b want 0", w_ready); end
    n_cmp++; if (r_ready !== 1'b0) begin n_fail++; $display("FAIL rst_r_ready: got %b want 0", r_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    n_cmp++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL rst_mem_en: got %b want 0", mem_en); end
    n_cmp++; if (mem_wmode !== 1'b0) begin n_fail++; $display("FAIL rst_mem_wmode: got %b want 0", mem_wmode); end
    n_cmp++; if (mem_addr !== 5'd0) begin n_fail++; $display("FAIL rst_mem_addr: got %0d want 0", mem_addr); end
    n_cmp++; if (mem_wmask !== 2'b00) begin n_fail++; $display("FAIL rst_mem_wmask: got %b want 00", mem_wmask); end
    n_cmp++; if (mem_wdata !== '0) begin n_fail++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
    n_cmp++; if (resp_data !== '0) begin n_fail++; $display("FAIL rst_resp_data: got %h want 0", resp_data); end
  endtask

  // Requests are held during the sweep to confirm they are not granted.
  task automatic test_init_sweep();
    logic [11:0] obs, exp;
    int writes;
    writes = 0;
    next_cycle();
    reset_n = 1'b1;
    w_valid = 1'b1; w_addr = 5'd9; w_mask = 2'b11; w_data = '0;
    r_valid = 1'b1; r_addr = 5'd9;
    #1;
    for (int k = 0; k < 32; k++) begin
      obs = {mem_en, mem_wmode, mem_addr, mem_wmask, init_done, w_ready, r_ready};
      exp = {1'b1, 1'b1, k[4:0], 2'b11, 1'b0, 1'b0, 1'b0};
      n_cmp++; if (obs !== exp || mem_wdata !== '0) begin
        n_fail++; $display("FAIL sweep_cycle_%0d: got %h/%h want %h/0", k, obs, mem_wdata, exp);
      end
      if (mem_en && mem_wmode) writes++;
      next_cycle();
      if (k == 31) begin w_valid = 1'b0; r_valid = 1'b0; end
      #1;
    end
    n_cmp++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL sweep_idle_after: mem_en got %b want 0", mem_en); end
    n_cmp++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL sweep_init_done: got %b want 1", init_done); end
    n_cmp++; if (writes != 32) begin n_fail++; $display("FAIL sweep_write_count: got %0d want 32", writes); end
  endtask

  task automatic test_readback_zero();
    next_cycle();
    resp_ready = 1'b1; r_valid = 1'b1; r_addr = 5'd7;
    #1;
    n_cmp++; if ({r_ready, mem_en, mem_wmode, mem_addr} !== {1'b1, 1'b1, 1'b0, 5'd7}) begin
      n_fail++; $display("FAIL rd7_issue: got %b%b%b/%0d want 110/7", r_ready, mem_en, mem_wmode, mem_addr);
    end
    next_cycle(); r_valid = 1'b0; #1;
    n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rd7_early_valid: got %b want 0", resp_valid); end
    next_cycle(); #1;
    n_cmp++; if (resp_valid !== 1'b1 || resp_data !== '0) begin
      n_fail++; $display("FAIL rd7_data: got %b/%h want 1/0", resp_valid, resp_data);
    end
    next_cycle(); #1;
    n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rd7_drained: got %b want 0", resp_valid); end
  endtask

  // Lane mask plus read-after-write on the very next cycle.
  task automatic test_mask_raw();
    logic [227:0] exp;
    exp = '0;
    exp[113:0] = '1;
    next_cycle();
    w_valid = 1'b1; w_addr = 5'd5; w_mask = 2'b01; w_data = '1;
    #1;
    n_cmp++; if ({w_ready, mem_en, mem_wmode, mem_wmask} !== 5'b11101) begin
      n_fail++; $display("FAIL wr5_issue: got %b%b%b%b want 11101", w_ready, mem_en, mem_wmode, mem_wmask);
    end
    next_cycle(); w_valid = 1'b0; r_valid = 1'b1; r_addr = 5'd5; #1;
    n_cmp++; if (r_ready !== 1'b1) begin n_fail++; $display("FAIL rd5_ready: got %b want 1", r_ready); end
    next_cycle(); r_valid = 1'b0; #1;
    n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rd5_early_valid: got %b want 0", resp_valid); end
    next_cycle(); #1;
    n_cmp++; if (resp_valid !== 1'b1 || resp_data !== exp) begin
      n_fail++; $display("FAIL rd5_data: got %b/%h want 1/%h", resp_valid, resp_data, exp);
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic exp_rd;
    next_cycle();
    resp_ready = 1'b1;
    w_valid = 1'b1; w_addr = 5'd20; w_mask = 2'b11; w_data = '0;
    r_valid = 1'b1; r_addr = 5'd21;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_rd = (i % 2 == 0);
      n_cmp++; if ({r_ready, w_ready} !== {exp_rd, ~exp_rd}) begin
        n_fail++; $display("FAIL rr_grant_%0d: got r%b w%b want r%b w%b", i, r_ready, w_ready, exp_rd, ~exp_rd);
      end
      next_cycle();
    end
    w_valid = 1'b0; r_valid = 1'b0;
    repeat (3) next_cycle();
    #1;
    n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drained: got %b want 0", resp_valid); end
  endtask

  task automatic test_back_to_back();
    int accepts, rx, issue_cycles;
    for (int a = 0; a < 32; a++) begin
      next_cycle();
      w_valid = 1'b1; w_addr = 5'(a); w_mask = 2'b11; w_data = 228'(a);
      #1;
      n_cmp++; if (w_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_wr_%0d: w_ready got %b want 1", a, w_ready); end
    end
    next_cycle();
    w_valid = 1'b0; resp_ready = 1'b1;
    accepts = 0; rx = 0; issue_cycles = 0;
    for (int c = 0; c < 40; c++) begin
      r_valid = (accepts < 32);
      r_addr  = 5'(accepts);
      #1;
      if (r_valid) issue_cycles++;
      if (resp_valid) begin
        n_cmp++; if (resp_data !== 228'(rx)) begin
          n_fail++; $display("FAIL b2b_resp_%0d: got %h want %h", rx, resp_data, 228'(rx));
        end
        rx++;
      end
      if (r_valid && r_ready) accepts++;
      next_cycle();
    end
    r_valid = 1'b0;
    n_cmp++; if (accepts != 32 || issue_cycles != 32) begin
      n_fail++; $display("FAIL b2b_throughput: got %0d accepts in %0d cycles want 32 in 32", accepts, issue_cycles);
    end
    n_cmp++; if (rx != 32) begin n_fail++; $display("FAIL b2b_resp_count: got %0d want 32", rx); end
  endtask

  task automatic test_backpressure();
    int accepts;
    logic exp;
    next_cycle();
    resp_ready = 1'b0; r_valid = 1'b1; r_addr = 5'd10; accepts = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      exp = (i < 2);
      n_cmp++; if (r_ready !== exp) begin n_fail++; $display("FAIL bp_ready_%0d: got %b want %b", i, r_ready, exp); end
      if (r_ready) accepts++;
      next_cycle();
      r_addr = 5'(10 + accepts);
    end
    resp_ready = 1'b1; r_addr = 5'd12;
    #1;
    n_cmp++; if (resp_valid !== 1'b1 || resp_data !== 228'd10) begin
      n_fail++; $display("FAIL bp_head0: got %b/%h want 1/a", resp_valid, resp_data);
    end
    n_cmp++; if (r_ready !== 1'b1) begin n_fail++; $display("FAIL bp_resume: r_ready got %b want 1", r_ready); end
    next_cycle(); r_valid = 1'b0; #1;
    n_cmp++; if (resp_valid !== 1'b1 || resp_data !== 228'd11) begin
      n_fail++; $display("FAIL bp_head1: got %b/%h want 1/b", resp_valid, resp_data);
    end
    next_cycle(); #1;
    n_cmp++; if (resp_valid !== 1'b1 || resp_data !== 228'd12) begin
      n_fail++; $display("FAIL bp_head2: got %b/%h want 1/c", resp_valid, resp_data);
    end
    next_cycle(); #1;
    n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b want 0", resp_valid); end
  endtask

  task automatic test_reset_midop();
    next_cycle();
    resp_ready = 1'b0; r_valid = 1'b1; r_addr = 5'd7;
    #1;
    n_cmp++; if (r_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rd_ready: got %b want 1", r_ready); end
    next_cycle(); r_valid = 1'b0;
    next_cycle(); #1;
    n_cmp++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pending: got %b want 1", resp_valid); end
    reset_n = 1'b0; #1;
    n_cmp++; if (resp_valid !== 1'b0 || mem_en !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_async: resp_valid/mem_en got %b%b want 00", resp_valid, mem_en);
    end
    next_cycle(); reset_n = 1'b1; #1;
    for (int k = 0; k <= 12; k++) begin
      n_cmp++; if (mem_en !== 1'b1 || mem_addr !== k[4:0]) begin
        n_fail++; $display("FAIL mid_sweep_%0d: en/addr got %b/%0d want 1/%0d", k, mem_en, mem_addr, k);
      end
      if (k < 12) begin next_cycle(); #1; end
    end
    reset_n = 1'b0; #1;
    n_cmp++; if (mem_en !== 1'b0 || init_done !== 1'b0) begin
      n_fail++; $display("FAIL mid_sweep_rst: en/done got %b%b want 00", mem_en, init_done);
    end
    next_cycle(); reset_n = 1'b1; #1;
    n_cmp++; if (mem_en !== 1'b1 || mem_addr !== 5'd0) begin
      n_fail++; $display("FAIL mid_restart: en/addr got %b/%0d want 1/0", mem_en, mem_addr);
    end
    repeat (32) next_cycle();
    #1;
    n_cmp++; if (init_done !== 1'b1 || mem_en !== 1'b0) begin
      n_fail++; $display("FAIL mid_done: done/en got %b%b want 10", init_done, mem_en);
    end
  endtask

  initial begin
    test_reset();
    test_init_sweep();
    test_readback_zero();
    test_mask_raw();
    test_round_robin();
    test_back_to_back();
    test_backpressure();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end
endmodule

// File: doc/array_11_port_ctrl.md
# array_11_port_ctrl

Sequencer and arbiter for the 32 x 228-bit single-port RW array macro (`array_11_ext`: one RW port, 2 write-mask lanes of 114 bits, read data valid the cycle after a read enable). It zero-fills the array after reset. It then shares the single RW port between one write requester and one read requester using round-robin arbitration. Read data is returned through a 2-entry response FIFO with valid/ready backpressure. The block sits between the pipeline's table logic and the macro instance.

## Interface
- `INIT_EN`, default 1: 1 runs the zero-fill sweep after reset; 0 skips it.
- `clock`  in  1  single clock for the block and the macro.
- `reset_n`  in  1  asynchronous, active-low reset.
- `init_done`  out  1  high once the array is usable.
- `w_valid` / `w_ready`  in / out  1 / 1  write request handshake.
- `w_addr` / `w_mask` / `w_data`  in  5 / 2 / 228  write address, per-lane mask (bit i covers data[i*114 +: 114]), write data.
- `r_valid` / `r_ready`  in / out  1 / 1  read request handshake.
- `r_addr`  in  5  read address.
- `resp_valid` / `resp_ready`  out / in  1 / 1  read response handshake.
- `resp_data`  out  228  read data at the response FIFO head.
- `mem_en`, `mem_wmode`  out  1 each  to macro `RW0_en` / `RW0_wmode`.
- `mem_addr` / `mem_wmask` / `mem_wdata`  out  5 / 2 / 228  to macro `RW0_addr` / `RW0_wmask` / `RW0_wdata`.
- `mem_rdata`  in  228  from macro `RW0_rdata`.

## Operation
- States: `INIT`, `RUN`.
- Reset entry state: `INIT` if `INIT_EN`=1, otherwise `RUN`.
- `INIT` sweep:
  - Counter runs 0..31.
  - Each cycle drives `mem_en`=1, `mem_wmode`=1, `mem_wmask`=2'b11, `mem_wdata`=0, `mem_addr`=counter.
  - After address 31 the state moves to `RUN`.
  - `w_ready`=`r_ready`=0 throughout.
- `RUN`: at most one macro access per cycle.
  - Write eligible: `w_valid`=1.
  - Read eligible: `r_valid`=1 and credit available, where credit = (fifo_count + inflight − pop) < 2, inflight = a read was issued in the previous cycle, pop = `resp_valid` & `resp_ready`.
- Single eligible requester: it is granted.
- Both eligible: the requester selected by the round-robin pointer is granted.
  - Pointer resets to "read".
  - After a contested grant the pointer moves to the other requester.
  - Uncontested grants leave the pointer unchanged.
- Granted write:
  - `w_ready`=1.
  - `mem_en`=1, `mem_wmode`=1, `mem_addr`/`mem_wmask`/`mem_wdata` taken from the `w_*` inputs.
  - `w_mask`=0 is still granted and consumes the slot; no bits are written.
- Granted read:
  - `r_ready`=1, `mem_en`=1, `mem_wmode`=0, `mem_addr`=`r_addr`.
  - Next cycle `mem_rdata` is pushed into the response FIFO.
- Idle cycle: `mem_en`=0. The other `mem_*` outputs hold their last value.
- Response FIFO:
  - 2 entries, FIFO order, `resp_valid` = count ≠ 0.
  - Push and pop in the same cycle is allowed.
  - By construction of the credit rule the FIFO never overflows.
- Reset mid-operation:
  - All state clears asynchronously.
  - The in-flight read and the FIFO contents are discarded.
  - The sweep restarts at address 0.

## Timing
- Reset values:
  - `init_done`=0 when `INIT_EN`=1, 1 when `INIT_EN`=0.
  - `w_ready`=0, `r_ready`=0, `resp_valid`=0, `mem_en`=0, `mem_wmode`=0, `mem_addr`=0, `mem_wmask`=0, `mem_wdata`=0, `resp_data`=0.
- `w_ready`, `r_ready` and all `mem_*` outputs are combinational from the current state and the request inputs.
- Init timing:
  - Sweep writes occupy clock edges 1..32 after reset release.
  - `init_done` rises after the edge that writes address 31 and stays high until reset.
- Read latency: the request-accept edge is N; `mem_rdata` is captured at edge N+1; `resp_valid` is high after edge N+1.
- Throughput: a read can be issued every cycle while `resp_ready`=1.
- Backpressure:
  - With `resp_ready`=0, at most 2 reads are outstanding (FIFO plus in flight).
  - `r_ready` drops until an entry is popped.
- Read-after-write: a write accepted at edge N followed by a read of the same address at edge N+1 returns the new data.

## Test plan
- Reset, then no requests for 33 cycles: `mem_en`=1 and `mem_wmode`=1 for exactly 32 cycles covering addresses 0..31 in order; `init_done` rises after the 32nd write; readback of address 7 returns 228'h0.
- Write address 5, mask 2'b01, data all-ones; then read address 5: `resp_data` low 114 bits = 1s, high 114 bits = 0; `resp_valid` high one cycle after `r_ready`.
- `w_valid` and `r_valid` held high for 4 cycles with `resp_ready`=1: grants alternate read, write, read, write.
- `resp_ready`=0 with `r_valid` held high: exactly 2 reads accepted, then `r_ready`=0. Raising `resp_ready` drains both responses in address order and resumes issue.
- Back-to-back reads of addresses 0..31 after writing data=address: 32 accepts in 32 cycles; responses in order, values 0..31.
- `reset_n` asserted low during sweep address 12 and with one response pending: `resp_valid`=0 immediately; the sweep restarts at address 0 after release.
